// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache line transactions onto one fixed-latency main memory port.
// Ties alternate by last grant; every transaction runs IDLE -> BUSY (LATENCY cycles) -> RESP.
module mem_arbiter #(
    parameter int LATENCY = 5,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_line,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [31:0]       dc_addr,
    input  logic [LINE_W-1:0] dc_wline,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_line,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grantDc_q, grantDc_d;
    logic              lastDc_q, lastDc_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] icLine_q, icLine_d;
    logic [LINE_W-1:0] dcLine_q, dcLine_d;
    logic              icAck_q, icAck_d;
    logic              dcAck_q, dcAck_d;

    logic              pickDc;
    logic [31:0]       selAddr;
    logic              lastCycle;

    assign lastCycle = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            grantDc_q <= 1'b0;
            lastDc_q  <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wline_q   <= '0;
            icLine_q  <= '0;
            dcLine_q  <= '0;
            icAck_q   <= 1'b0;
            dcAck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grantDc_q <= grantDc_d;
            lastDc_q  <= lastDc_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wline_q   <= wline_d;
            icLine_q  <= icLine_d;
            dcLine_q  <= dcLine_d;
            icAck_q   <= icAck_d;
            dcAck_q   <= dcAck_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grantDc_d = grantDc_q;
        lastDc_d  = lastDc_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wline_d   = wline_q;
        icLine_d  = icLine_q;
        dcLine_d  = dcLine_q;
        icAck_d   = 1'b0;
        dcAck_d   = 1'b0;
        pickDc    = 1'b0;
        selAddr   = '0;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the dcache wins unless it was the last one served.
                    pickDc    = dc_req && (!ic_req || !lastDc_q);
                    selAddr   = pickDc ? dc_addr : ic_addr;
                    grantDc_d = pickDc;
                    lastDc_d  = pickDc;
                    addr_d    = {selAddr[31:4], 4'b0000};
                    we_d      = pickDc && dc_we;
                    if (pickDc) begin
                        wline_d = dc_wline;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (grantDc_q) begin
                        dcAck_d = 1'b1;
                        if (!we_q) begin
                            dcLine_d = mem_rdata;
                        end
                    end else begin
                        icAck_d  = 1'b1;
                        icLine_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign mem_addr  = (state_q == BUSY) ? addr_q : 32'h0;
    assign mem_we    = lastCycle && grantDc_q && we_q;
    assign mem_wdata = wline_q;
    assign ic_ack    = icAck_q;
    assign dc_ack    = dcAck_q;
    assign ic_line   = icLine_q;
    assign dc_line   = dcLine_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: lane 0 uses LATENCY=5, lane 1 uses LATENCY=1.
// Each lane predicts grants at acceptance and compares them against acks and memory strobes.
module tb_mem_arbiter;

    typedef struct {
        bit           isDc;
        bit           isWr;
        logic [31:0]  addr;
        logic [127:0] line;
        int           ackCyc;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    int           cyc = 0;
    int           cmpCount = 0;
    int           failCount = 0;
    int           pendCount [2];

    logic         icReq    [2];
    logic [31:0]  icAddr   [2];
    logic         icAck    [2];
    logic [127:0] icLine   [2];
    logic         dcReq    [2];
    logic         dcWe     [2];
    logic [31:0]  dcAddr   [2];
    logic [127:0] dcWline  [2];
    logic         dcAck    [2];
    logic [127:0] dcLine   [2];
    logic [31:0]  memAddr  [2];
    logic         memWe    [2];
    logic [127:0] memWdata [2];
    logic [127:0] memRdata [2];
    logic         busy     [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content depends on the cycle too, so capturing on the wrong edge is visible.
    function automatic logic [127:0] pattern(input logic [31:0] a, input int salt);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1357_9BDF, a ^ 32'(salt) ^ 32'h0F0F_0000};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 5 : 1;

        mem_arbiter #(.LATENCY(L), .LINE_W(128)) dut (
            .clk(clk), .reset(reset),
            .ic_req(icReq[g]), .ic_addr(icAddr[g]), .ic_ack(icAck[g]), .ic_line(icLine[g]),
            .dc_req(dcReq[g]), .dc_we(dcWe[g]), .dc_addr(dcAddr[g]), .dc_wline(dcWline[g]),
            .dc_ack(dcAck[g]), .dc_line(dcLine[g]),
            .mem_addr(memAddr[g]), .mem_we(memWe[g]), .mem_wdata(memWdata[g]),
            .mem_rdata(memRdata[g]), .busy(busy[g])
        );

        assign memRdata[g] = pattern(memAddr[g], cyc);

        txn_t         q[$];
        txn_t         t;
        bit           prevBusy = 1'b0;
        bit           lastDc = 1'b0;
        bit           pickDc;
        bit           expWe;
        logic [31:0]  a;
        logic [127:0] mIc = '0;
        logic [127:0] mDc = '0;

        always @(negedge clk) begin
            if (!reset) begin
                q.delete();
                prevBusy = 1'b0;
                lastDc   = 1'b0;
                mIc      = '0;
                mDc      = '0;
                checkOutput("rst_ctl", {busy[g], icAck[g], dcAck[g], memWe[g]}, 4'b0000);
                checkOutput("rst_addr", memAddr[g], 32'h0);
                checkOutput("rst_lines", icLine[g] | dcLine[g], 128'h0);
            end else begin
                if (q.size() > 0 && cyc > q[0].ackCyc) begin
                    checkOutput("ack_late", cyc, q[0].ackCyc);
                    void'(q.pop_front());
                end
                checkOutput("ack_excl", icAck[g] & dcAck[g], 1'b0);
                if (icAck[g] || dcAck[g]) begin
                    if (q.size() == 0) begin
                        checkOutput("spurious_ack", {icAck[g], dcAck[g]}, 2'b00);
                    end else begin
                        t = q.pop_front();
                        checkOutput("ack_who", {icAck[g], dcAck[g]}, t.isDc ? 2'b01 : 2'b10);
                        checkOutput("ack_cyc", cyc, t.ackCyc);
                        if (!t.isWr) begin
                            if (t.isDc) mDc = t.line;
                            else        mIc = t.line;
                        end
                        checkOutput("ic_line", icLine[g], mIc);
                        checkOutput("dc_line", dcLine[g], mDc);
                    end
                end
                if (busy[g] && !prevBusy) begin
                    pickDc = dcReq[g] && (!icReq[g] || !lastDc);
                    lastDc = pickDc;
                    a = pickDc ? dcAddr[g] : icAddr[g];
                    a[3:0] = 4'h0;
                    t.isDc   = pickDc;
                    t.isWr   = pickDc && dcWe[g];
                    t.addr   = a;
                    t.line   = t.isWr ? dcWline[g] : pattern(a, cyc - 1 + L);
                    t.ackCyc = cyc + L;
                    q.push_back(t);
                    checkOutput("grant_addr", memAddr[g], a);
                end
                expWe = (q.size() > 0) && q[0].isWr && (cyc == q[0].ackCyc - 1);
                checkOutput("mem_we", memWe[g], expWe);
                if (expWe) begin
                    checkOutput("we_addr", memAddr[g], q[0].addr);
                    checkOutput("we_data", memWdata[g], q[0].line);
                end
                prevBusy = busy[g];
            end
            pendCount[g] = q.size();
        end
    end

    task automatic applyStimulus(input int g, input bit icR, input logic [31:0] icA, input bit dcR,
                                 input bit dcW, input logic [31:0] dcA, input logic [127:0] dcL);
        icReq[g]   = icR;
        icAddr[g]  = icA;
        dcReq[g]   = dcR;
        dcWe[g]    = dcW;
        dcAddr[g]  = dcA;
        dcWline[g] = dcL;
    endtask

    task automatic waitAck(input int g, input bit wantIc, input bit wantDc, input int budget,
                           output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((wantIc && icAck[g]) || (wantDc && dcAck[g])) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        checkOutput("wait_ack", seen, 1'b1);
        #1;
    endtask

    task automatic waitBusy(input int g, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = busy[g];
        end
        checkOutput("wait_busy", seen, 1'b1);
        #1;
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dcAt, icAt, at;
        for (int g = 0; g < 2; g++) applyStimulus(g, 0, 0, 0, 0, 0, '0);
        #1 doReset(3);

        // Single icache fill with an unaligned address.
        @(negedge clk); #1;
        applyStimulus(0, 1, 32'h0000_0104, 0, 0, 0, '0);
        waitAck(0, 1, 0, 12, at);
        icReq[0] = 1'b0;

        // Simultaneous requests straight out of reset: dcache first, icache 7 cycles later.
        doReset(2);
        applyStimulus(0, 1, 32'h0000_2048, 1, 0, 32'h0000_0200, '0);
        waitAck(0, 0, 1, 12, dcAt);
        dcReq[0] = 1'b0;
        waitAck(0, 1, 0, 12, icAt);
        icReq[0] = 1'b0;
        checkOutput("tie_gap", icAt - dcAt, 7);

        // Write-back; inputs scrambled after grant must not leak in.
        @(negedge clk); #1;
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_030C, 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004);
        waitBusy(0, 4);
        dcAddr[0]  = 32'hFFFF_FFF0;
        dcWline[0] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        waitAck(0, 0, 1, 12, at);
        dcReq[0] = 1'b0;

        // Both held through four transactions; grants must alternate.
        doReset(2);
        applyStimulus(0, 1, 32'h0000_4444, 1, 0, 32'h0000_8888, '0);
        for (int k = 0; k < 4; k++) begin
            waitAck(0, 1, 1, 12, at);
        end
        icReq[0] = 1'b0;
        dcReq[0] = 1'b0;

        // Reset two cycles into a write aborts it; the held request is served afterwards.
        @(negedge clk); #1;
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0A00, 128'hCAFE_0000_CAFE_1111_CAFE_2222_CAFE_3333);
        waitBusy(0, 4);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_ctl", {busy[0], icAck[0], dcAck[0], memWe[0]}, 4'b0000);
        checkOutput("abort_addr", memAddr[0], 32'h0);
        @(negedge clk); #1 reset = 1'b1;
        waitAck(0, 0, 1, 12, at);
        dcReq[0] = 1'b0;

        // LATENCY=1 lane: held fill, dropped-request fill, then a write.
        @(negedge clk); #1;
        applyStimulus(1, 1, 32'h0000_07F4, 0, 0, 0, '0);
        waitAck(1, 1, 0, 6, at);
        icReq[1] = 1'b0;
        @(negedge clk); #1;
        applyStimulus(1, 1, 32'h0000_07F8, 0, 0, 0, '0);
        waitBusy(1, 4);
        icReq[1]  = 1'b0;
        icAddr[1] = 32'h0000_DEA0;
        waitAck(1, 1, 0, 6, at);
        @(negedge clk); #1;
        applyStimulus(1, 0, 0, 1, 1, 32'h0000_050C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        waitBusy(1, 4);
        dcWline[1] = '0;
        waitAck(1, 0, 1, 6, at);
        dcReq[1] = 1'b0;

        repeat (6) @(negedge clk);
        #1;
        checkOutput("drain0", pendCount[0], 0);
        checkOutput("drain1", pendCount[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule
